// File: rtl/slon5_pkg.sv
// Shared definitions for the slon5 display scan path: segment glyph table,
// decoder and receive FSM states.
package slon5_pkg;

    localparam int SEG_W = 8;
    typedef logic [SEG_W-1:0] Seg_t;

    // gfedcba glyphs for hex 0..F; the encoder indexes the same table
    localparam logic [6:0] SegTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {SYNC, COLLECT, DONE} ScanRxState_t;

    // Returns {illegal, nibble}; unknown glyphs decode to nibble 0
    function automatic logic [4:0] seg2hex(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b1_0000;
        for (int i = 0; i < 16; i++)
            if (seg == SegTable[i]) res = {1'b0, 4'(i)};
        return res;
    endfunction

endpackage

// File: rtl/slon5_settle_cnt.sv
// Input register plus stable-sample counter; pulses accept once when a
// {dnum,dout} pair has been seen SETTLE_CYCLES consecutive times.
module slon5_settle_cnt #(
    parameter int IW            = 2,
    parameter int SW            = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_dnum,
    input  logic [SW-1:0] i_dout,
    output logic [IW-1:0] o_dnum,
    output logic [SW-1:0] o_dout,
    output logic          o_accept
);
    import slon5_pkg::*;

    localparam int            CW  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(SETTLE_CYCLES);

    logic [IW-1:0] r_dnum;
    logic [SW-1:0] r_dout;
    logic [CW-1:0] r_cnt;
    logic          r_accept;
    logic          w_changed;
    logic [CW-1:0] w_cnt_nxt;

    // The count tracks the value being loaded into the input register, so it
    // is aligned with r_dnum/r_dout and accept coincides with the settled value.
    always_comb begin
        w_changed = {i_dnum, i_dout} != {r_dnum, r_dout};
        if (w_changed)
            w_cnt_nxt = CW'(1);
        else if (r_cnt == SAT)
            w_cnt_nxt = r_cnt;
        else
            w_cnt_nxt = r_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dnum   <= '0;
            r_dout   <= '0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_dnum   <= i_dnum;
            r_dout   <= i_dout;
            r_cnt    <= w_cnt_nxt;
            r_accept <= (w_cnt_nxt == SAT) && (w_changed || r_cnt != SAT);
        end
    end

    assign o_dnum   = r_dnum;
    assign o_dout   = r_dout;
    assign o_accept = r_accept;

endmodule

// File: rtl/slon5_scan_rx.sv
// slon5 scan receiver: decodes settled digit patterns and reassembles a full
// display frame, flagging scan-order violations.
module slon5_scan_rx #(
    parameter int DIGIT_NUM     = 4,
    parameter int SEG_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         ref_clk,
    input  logic                         rst,
    input  logic [SEG_WIDTH-1:0]         dout_in,
    input  logic [$clog2(DIGIT_NUM)-1:0] dnum_in,
    output logic [4*DIGIT_NUM-1:0]       frame_data,
    output logic [DIGIT_NUM-1:0]         frame_dp,
    output logic                         frame_valid,
    output logic                         frame_err,
    output logic [DIGIT_NUM-1:0]         seg_err
);
    import slon5_pkg::*;

    localparam int            IW   = $clog2(DIGIT_NUM);
    localparam logic [IW-1:0] LAST = IW'(DIGIT_NUM - 1);

    logic [IW-1:0]        w_dnum;
    logic [SEG_WIDTH-1:0] w_dout;
    logic                 w_accept;
    logic [4:0]           w_dec;
    logic [IW-1:0]        w_held;

    ScanRxState_t r_state, w_state_nxt;
    logic [IW-1:0] r_exp, w_exp_nxt;
    logic          w_cap, w_err, w_done;

    logic [DIGIT_NUM-1:0][3:0] r_sh_nib, r_frame_data;
    logic [DIGIT_NUM-1:0]      r_sh_dp, r_sh_ill, r_frame_dp, r_seg_err;
    logic                      r_valid, r_err;

    slon5_settle_cnt #(
        .IW(IW), .SW(SEG_WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk(ref_clk), .rst(rst),
        .i_dnum(dnum_in), .i_dout(dout_in),
        .o_dnum(w_dnum), .o_dout(w_dout), .o_accept(w_accept)
    );

    assign w_dec  = seg2hex(w_dout[6:0]);
    assign w_held = (r_exp == '0) ? LAST : r_exp - IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_cap       = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_accept && w_dnum == '0) begin
                    w_cap       = 1'b1;
                    w_exp_nxt   = IW'(1);
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_dnum != w_held && w_dnum != r_exp) begin
                    w_err       = 1'b1;
                    w_state_nxt = SYNC;
                end else if (w_accept && w_dnum == r_exp) begin
                    w_cap = 1'b1;
                    if (r_exp == LAST)
                        w_state_nxt = DONE;
                    else
                        w_exp_nxt = r_exp + IW'(1);
                end
            end
            DONE: begin
                // digit 0 may already settle here when SETTLE_CYCLES is 1
                w_done      = 1'b1;
                w_state_nxt = COLLECT;
                w_exp_nxt   = '0;
                if (w_accept && w_dnum == '0) begin
                    w_cap     = 1'b1;
                    w_exp_nxt = IW'(1);
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_state      <= SYNC;
            r_exp        <= '0;
            r_sh_nib     <= '0;
            r_sh_dp      <= '0;
            r_sh_ill     <= '0;
            r_frame_data <= '0;
            r_frame_dp   <= '0;
            r_seg_err    <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_valid <= w_done;
            r_err   <= w_err;
            if (w_cap) begin
                r_sh_nib[w_dnum] <= w_dec[3:0];
                r_sh_dp[w_dnum]  <= w_dout[7];
                r_sh_ill[w_dnum] <= w_dec[4];
            end
            if (w_done) begin
                r_frame_data <= r_sh_nib;
                r_frame_dp   <= r_sh_dp;
                r_seg_err    <= r_sh_ill;
            end
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_dp    = r_frame_dp;
    assign seg_err     = r_seg_err;
    assign frame_valid = r_valid;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_slon5_scan_rx.sv
// Directed scoreboard bench for slon5_scan_rx: stimulus queues expected frame
// and error events, a negedge monitor pops and compares them.
module tb_slon5_scan_rx;

    localparam int S = 4;

    logic        ref_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dout_in = '0;
    logic [1:0]  dnum_in = '0;
    logic [15:0] frame_data;
    logic [3:0]  frame_dp;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  seg_err;

    typedef struct {
        bit          err;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  seg;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;

    slon5_scan_rx #(.DIGIT_NUM(4), .SEG_WIDTH(8), .SETTLE_CYCLES(S)) dut (
        .ref_clk(ref_clk), .rst(rst), .dout_in(dout_in), .dnum_in(dnum_in),
        .frame_data(frame_data), .frame_dp(frame_dp), .frame_valid(frame_valid),
        .frame_err(frame_err), .seg_err(seg_err)
    );

    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic [7:0] p, input int n);
        dnum_in = d;
        dout_in = p;
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic push(input bit err, input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] seg, input int c);
        exp_t e;
        e.err = err; e.d = d; e.dp = dp; e.seg = seg; e.cyc = c;
        q.push_back(e);
    endtask

    // Full 0..3 scan, 6 cycles per digit; frame_valid expected 2+S cycles
    // after digit 3 is first presented.
    task automatic scan(input logic [7:0] p0, p1, p2, p3, input logic [15:0] ed,
                        input logic [3:0] edp, input logic [3:0] es);
        drive(2'd0, p0, 6);
        drive(2'd1, p1, 6);
        drive(2'd2, p2, 6);
        push(1'b0, ed, edp, es, cyc + 2 + S);
        drive(2'd3, p3, 6);
    endtask

    always @(negedge ref_clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            if (q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_event: valid=%0b err=%0b data=%0h (cycle %0d)",
                         frame_valid, frame_err, frame_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_is_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("event_is_valid", {31'd0, frame_valid}, {31'd0, !e.err});
                chk("frame_data", {16'd0, frame_data}, {16'd0, e.d});
                chk("frame_dp", {28'd0, frame_dp}, {28'd0, e.dp});
                chk("seg_err", {28'd0, seg_err}, {28'd0, e.seg});
                if (!e.err) chk("valid_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        @(posedge ref_clk); #1;
        chk("rst_data", {16'd0, frame_data}, 32'd0);
        chk("rst_flags", {25'd0, frame_valid, frame_err, frame_dp, seg_err[0]}, 32'd0);
        chk("rst_seg_err", {28'd0, seg_err}, 32'd0);
        @(posedge ref_clk); #1;
        rst = 1'b0;

        // clean frame 1,2,3,4
        scan(8'h06, 8'h5B, 8'h4F, 8'h66, 16'h4321, 4'b0000, 4'b0000);
        // dp + E on digit 2
        scan(8'h06, 8'h5B, 8'hF9, 8'h66, 16'h4E21, 4'b0100, 4'b0000);

        // digit 2 skipped: one error, old frame retained
        push(1'b1, 16'h4E21, 4'b0100, 4'b0000, 0);
        drive(2'd0, 8'h06, 6);
        drive(2'd1, 8'h5B, 6);
        drive(2'd3, 8'h66, 6);
        scan(8'h06, 8'h5B, 8'h4F, 8'h66, 16'h4321, 4'b0000, 4'b0000);

        // digit 1 glitch (3 < S samples) then digit 2
        push(1'b1, 16'h4321, 4'b0000, 4'b0000, 0);
        drive(2'd0, 8'h06, 6);
        drive(2'd1, 8'h5B, 3);
        drive(2'd2, 8'h4F, 6);
        drive(2'd3, 8'h66, 6);

        // illegal glyph on digit 3
        scan(8'h06, 8'h5B, 8'h4F, 8'h49, 16'h0321, 4'b0000, 4'b1000);

        // reset during digit 2 capture
        drive(2'd0, 8'h06, 6);
        drive(2'd1, 8'h5B, 6);
        drive(2'd2, 8'h4F, 2);
        rst = 1'b1;
        @(posedge ref_clk); #1;
        rst = 1'b0;
        chk("midrst_data", {16'd0, frame_data}, 32'd0);
        chk("midrst_dp", {28'd0, frame_dp}, 32'd0);
        chk("midrst_seg_err", {28'd0, seg_err}, 32'd0);
        chk("midrst_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        drive(2'd2, 8'h4F, 4);
        drive(2'd3, 8'h66, 6);
        scan(8'h06, 8'h5B, 8'h4F, 8'h66, 16'h4321, 4'b0000, 4'b0000);

        repeat (10) @(posedge ref_clk);
        #1;
        chk("pending_events", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/slon5_scan_rx.md
Name: slon5_scan_rx

Overview:
Receive end of the slon5 multiplexed display interface. The block samples the scanned digit-select (dnum) and segment (dout) lines that slon5_test drives. It decodes each settled segment pattern back to a hex nibble and reassembles one full display frame. It sits in the func test environment and in on-chip loopback self-test, as the checker for the slon5 scan output.

Parameters:
DIGIT_NUM, 4, number of scanned digits; must be 2..16.
SEG_WIDTH, 8, segment bus width; bits [6:0] = gfedcba, bit 7 = dp, active-high.
SETTLE_CYCLES, 4, consecutive identical samples required before a digit is accepted; must be 1..255.

Ports:
ref_clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
dout_in  in  SEG_WIDTH  segment pattern from the scanner.
dnum_in  in  $clog2(DIGIT_NUM)  binary index of the active digit.
frame_data  out  4*DIGIT_NUM  decoded nibbles; digit k at [4k+3:4k].
frame_dp  out  DIGIT_NUM  decimal-point bit per digit.
frame_valid  out  1  one-cycle pulse: frame_data/frame_dp updated.
frame_err  out  1  one-cycle pulse: scan order violation, frame discarded.
seg_err  out  DIGIT_NUM  per-digit flag: last accepted pattern was not a legal hex glyph.

Behaviour:
- Reset values: all outputs 0; state SYNC; stable counter 0; input registers 0.
- Input stage: dnum_in/dout_in registered once (dnum_r, dout_r). All logic uses the registered values.
- Stable counter:
  - Clears to 1 when {dnum_r,dout_r} differs from its previous value.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - "accept" is true for exactly one cycle, when the counter reaches SETTLE_CYCLES.
- Decode (combinational on dout_r[6:0]):
  - 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 map to 0..F.
  - Any other pattern gives nibble 0 and sets the illegal flag.
  - dp = dout_r[7].
- FSM:
  - SYNC: wait for accept with dnum_r==0, then capture digit 0, set expected index exp=1, go to COLLECT. Accepts with any other index are ignored.
  - COLLECT:
    - On accept with dnum_r==exp: capture into the shadow frame. If exp==DIGIT_NUM-1, go to DONE; else exp++.
    - If dnum_r changes to a value other than exp-1 (held) or exp (next): pulse frame_err and go to SYNC; the shadow frame is discarded.
  - DONE (one cycle): copy shadow frame, dp and illegal flags to frame_data/frame_dp/seg_err; pulse frame_valid; go to COLLECT with exp=0 to track the wrap-around to digit 0.
    - In COLLECT with exp=0, the held value is DIGIT_NUM-1.
    - An accept on digit 0 also counts as a capture.
- Outputs hold their last frame until the next DONE. frame_err never alters frame_data.
- Latency: frame_valid is asserted 2+SETTLE_CYCLES cycles after dout_in/dnum_in first present the final digit, assuming stable inputs. Timing: 1 input register + SETTLE_CYCLES of counting + 1 DONE cycle.
- Simultaneous events: an order violation takes priority over accept in the same cycle.
- Reset mid-frame: immediate return to SYNC; outputs cleared.
- Glitch: a digit that never holds SETTLE_CYCLES samples is not captured. If the next index then appears, it is a frame_err in COLLECT (digit skipped).

Decomposition:
- slon5_pkg gets:
  - typedef Seg_t = logic [SEG_WIDTH-1:0].
  - The 16-entry SegTable constant, shared with the slon5 encoder so both ends use one source.
  - function seg2hex returning {illegal, nibble}.
  - enum ScanRxState_t {SYNC, COLLECT, DONE}.
- Sub-module slon5_settle_cnt holds the input register, compare and saturating counter, and emits accept.

Test Plan:
- Scan digits 0..3 with patterns 0x06,0x5B,0x4F,0x66, each held 6 cycles, SETTLE_CYCLES=4 -> frame_valid pulse; frame_data=16'h4321, frame_dp=0, seg_err=0.
- Repeat the frame with dout 0xF9 (dp+E) on digit 2 -> second frame_valid; frame_data=16'h4E21, frame_dp=4'b0100.
- Sequence 0,1,3 (digit 2 skipped) -> frame_err pulse exactly once; frame_data keeps the previous value. After the next clean 0..3 scan -> frame_valid.
- Digit 1 held for only 3 cycles with SETTLE_CYCLES=4, then digit 2 -> frame_err; no frame_valid for that pass.
- Digit 3 pattern 0x49 (illegal) -> frame_valid with nibble 0 at [15:12]; seg_err=4'b1000.
- Assert rst for 1 cycle while digit 2 is being captured -> all outputs 0 the next cycle. The first frame_valid occurs only after a full 0..3 scan that starts at digit 0.
